// File: rtl/ser_word_rx.sv
// Serial-to-parallel receiver for framed 9-bit words with even parity.
// Good words are queued in a small FIFO and handed out over valid/ready.
module ser_word_rx #(
    parameter int unsigned DATA_W    = 9,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_sval,
    input  logic                 i_sdata,
    output logic [DATA_W-1:0]    o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_perr,
    output logic                 o_abort,
    output logic                 o_ovf,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);
    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {StIdle, StData, StPar} state_e;

    state_e                r_state, w_state_d;
    logic [CNT_W-1:0]      r_cnt, w_cnt_d;
    logic [DATA_W-1:0]     r_shift, w_shift_d;
    logic                  w_good, w_perr, w_abort;

    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
    logic [OCC_W-1:0]      r_occ;
    logic [DATA_W-1:0]     r_last;
    logic                  w_full, w_pop, w_push, w_ovf;

    logic                  r_perr, r_abort, r_ovf;
    logic [ERR_CNT_W-1:0]  r_err_cnt;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_shift_d = r_shift;
        w_good    = 1'b0;
        w_perr    = 1'b0;
        w_abort   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_sval) begin
                    w_shift_d = {{(DATA_W-1){1'b0}}, i_sdata};
                    w_cnt_d   = CNT_W'(1);
                    w_state_d = StData;
                end
            end
            StData: begin
                if (i_sval) begin
                    w_shift_d[r_cnt] = i_sdata;
                    if (r_cnt == CNT_W'(DATA_W - 1)) begin
                        w_state_d = StPar;
                    end else begin
                        w_cnt_d = r_cnt + CNT_W'(1);
                    end
                end else begin
                    w_abort   = 1'b1;
                    w_cnt_d   = '0;
                    w_state_d = StIdle;
                end
            end
            StPar: begin
                w_cnt_d   = '0;
                w_state_d = StIdle;
                if (i_sval) begin
                    // Even parity: data bits XOR parity bit must be zero
                    if (^{r_shift, i_sdata}) begin
                        w_perr = 1'b1;
                    end else begin
                        w_good = 1'b1;
                    end
                end else begin
                    w_abort = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign w_full = (r_occ == OCC_W'(DEPTH));
    assign w_pop  = (r_occ != '0) && i_ready;
    // A pop on a full buffer frees the slot for a push in the same cycle
    assign w_push = w_good && (!w_full || w_pop);
    assign w_ovf  = w_good && w_full && !w_pop;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_shift <= w_shift_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_last   <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= r_shift;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_last   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_occ <= r_occ + OCC_W'(1);
            end else if (!w_push && w_pop) begin
                r_occ <= r_occ - OCC_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_perr    <= 1'b0;
            r_abort   <= 1'b0;
            r_ovf     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_perr  <= w_perr;
            r_abort <= w_abort;
            r_ovf   <= w_ovf;
            if ((r_perr || r_abort || r_ovf) && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            end
        end
    end

    // Last popped word is shown while empty so o_data never changes spuriously
    assign o_data    = (r_occ == '0) ? r_last : r_mem[r_rd_ptr];
    assign o_valid   = (r_occ != '0);
    assign o_perr    = r_perr;
    assign o_abort   = r_abort;
    assign o_ovf     = r_ovf;
    assign o_err_cnt = r_err_cnt;
endmodule

// File: tb/tb_ser_word_rx.sv
// Bench for ser_word_rx: frame table, directed corner sequences and random traffic,
// every cycle checked against a queue-based receiver model.
module tb_ser_word_rx;
    localparam int DW    = 9;
    localparam int DEPTH = 2;
    localparam int CW    = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          sval;
    logic          sdata;
    logic          ready;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          o_perr;
    logic          o_abort;
    logic          o_ovf;
    logic [CW-1:0] o_err_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    ser_word_rx #(
        .DATA_W    (DW),
        .DEPTH     (DEPTH),
        .ERR_CNT_W (CW)
    ) u_dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_sval    (sval),
        .i_sdata   (sdata),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .i_ready   (ready),
        .o_perr    (o_perr),
        .o_abort   (o_abort),
        .o_ovf     (o_ovf),
        .o_err_cnt (o_err_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: raw bit queue of the frame in progress and a word queue
    bit            mbits[$];
    logic [DW-1:0] mq[$];
    logic [DW-1:0] mlast;
    bit            mperr, mabort, movf;
    int            mcnt;

    task automatic model_reset();
        mbits.delete();
        mq.delete();
        mlast  = '0;
        mperr  = 0;
        mabort = 0;
        movf   = 0;
        mcnt   = 0;
    endtask

    task automatic model_edge();
        bit            pop;
        bit            p;
        logic [DW-1:0] w;
        if (rst) begin
            model_reset();
            return;
        end
        pop = (mq.size() != 0) && ready;
        if ((mperr || mabort || movf) && mcnt < 255) mcnt++;
        mperr  = 0;
        mabort = 0;
        movf   = 0;
        if (pop) mlast = mq.pop_front();
        if (sval) begin
            mbits.push_back(sdata);
            if (mbits.size() == DW + 1) begin
                w = '0;
                p = 0;
                for (int i = 0; i < DW; i++) w[i] = mbits[i];
                for (int i = 0; i <= DW; i++) p ^= mbits[i];
                if (p) mperr = 1;
                else if (mq.size() < DEPTH) mq.push_back(w);
                else movf = 1;
                mbits.delete();
            end
        end else if (mbits.size() != 0) begin
            mabort = 1;
            mbits.delete();
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_all();
        chk("valid", 32'(o_valid), 32'(mq.size() != 0));
        chk("data", 32'(o_data), 32'((mq.size() != 0) ? mq[0] : mlast));
        chk("perr", 32'(o_perr), 32'(mperr));
        chk("abort", 32'(o_abort), 32'(mabort));
        chk("ovf", 32'(o_ovf), 32'(movf));
        chk("err_cnt", 32'(o_err_cnt), 32'(mcnt));
    endtask

    // Inputs are set before calling; model advances, then DUT is sampled 1 after the edge
    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // rdy_par >= 0 overrides i_ready for the parity-bit cycle only
    task automatic send_frame(input logic [DW-1:0] d, input logic p, input int rdy_par);
        for (int i = 0; i < DW; i++) begin
            sval  = 1'b1;
            sdata = d[i];
            cycle();
        end
        sdata = p;
        if (rdy_par >= 0) ready = rdy_par[0];
        cycle();
    endtask

    task automatic idle(input int n);
        sval  = 1'b0;
        sdata = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [DW-1:0] data;
        logic          par;
        logic          exp_perr;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{data: 9'h0A5, par: 1'b0, exp_perr: 1'b0, exp_valid: 1'b1, exp_data: 9'h0A5};
        vecs[1] = '{data: 9'h001, par: 1'b0, exp_perr: 1'b1, exp_valid: 1'b0, exp_data: 9'h0A5};
        vecs[2] = '{data: 9'h1FF, par: 1'b1, exp_perr: 1'b0, exp_valid: 1'b1, exp_data: 9'h1FF};
        vecs[3] = '{data: 9'h000, par: 1'b0, exp_perr: 1'b0, exp_valid: 1'b1, exp_data: 9'h000};
        vecs[4] = '{data: 9'h100, par: 1'b1, exp_perr: 1'b0, exp_valid: 1'b1, exp_data: 9'h100};
        vecs[5] = '{data: 9'h0A5, par: 1'b1, exp_perr: 1'b1, exp_valid: 1'b0, exp_data: 9'h100};

        rst   = 1'b1;
        sval  = 1'b0;
        sdata = 1'b0;
        ready = 1'b1;
        model_reset();
        idle(2);
        chk("reset_valid", 32'(o_valid), 32'd0);
        chk("reset_data", 32'(o_data), 32'd0);
        chk("reset_err_cnt", 32'(o_err_cnt), 32'd0);
        rst = 1'b0;
        idle(1);

        // Frame table, each frame drained before the next
        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].data, vecs[v].par, -1);
            chk("tbl_perr", 32'(o_perr), 32'(vecs[v].exp_perr));
            chk("tbl_valid", 32'(o_valid), 32'(vecs[v].exp_valid));
            chk("tbl_data", 32'(o_data), 32'(vecs[v].exp_data));
            idle(2);
            chk("tbl_drained", 32'(o_valid), 32'd0);
        end
        chk("tbl_err_cnt", 32'(o_err_cnt), 32'd2);

        // Abort after 4 data bits, then a good frame
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sval  = 1'b1;
            sdata = 1'b1;
            cycle();
        end
        idle(1);
        chk("abort_pulse", 32'(o_abort), 32'd1);
        send_frame(9'h1FF, 1'b1, -1);
        chk("abort_next_data", 32'(o_data), 32'h1FF);
        chk("abort_next_valid", 32'(o_valid), 32'd1);
        idle(2);
        chk("abort_err_cnt", 32'(o_err_cnt), 32'd1);

        // Overflow with three back-to-back frames, then full-buffer push with pop
        ready = 1'b0;
        send_frame(9'h011, 1'b0, -1);
        send_frame(9'h022, 1'b0, -1);
        send_frame(9'h033, 1'b0, -1);
        chk("ovf_pulse", 32'(o_ovf), 32'd1);
        chk("ovf_head", 32'(o_data), 32'h011);
        send_frame(9'h044, 1'b0, 1);
        chk("full_pop_no_ovf", 32'(o_ovf), 32'd0);
        chk("full_pop_head", 32'(o_data), 32'h022);
        sval = 1'b0;
        idle(1);
        chk("pop_044", 32'(o_data), 32'h044);
        idle(1);
        chk("empty_after_pops", 32'(o_valid), 32'd0);
        chk("empty_holds_data", 32'(o_data), 32'h044);

        // Reset mid-frame with one word buffered
        ready = 1'b0;
        send_frame(9'h0A5, 1'b0, -1);
        for (int i = 0; i < 3; i++) begin
            sval  = 1'b1;
            sdata = 1'b1;
            cycle();
        end
        chk("pre_rst_valid", 32'(o_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(o_valid), 32'd0);
        chk("async_rst_err_cnt", 32'(o_err_cnt), 32'd0);
        chk("async_rst_data", 32'(o_data), 32'd0);
        idle(1);
        rst   = 1'b0;
        ready = 1'b1;
        send_frame(9'h155, 1'b1, -1);
        chk("post_rst_valid", 32'(o_valid), 32'd1);
        chk("post_rst_data", 32'(o_data), 32'h155);
        idle(2);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            sval  = ($urandom_range(0, 9) != 0);
            sdata = 1'($urandom);
            ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        idle(3);

        // Error counter saturation
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 260; i++) send_frame(9'h001, 1'b0, -1);
        idle(3);
        chk("err_cnt_sat", 32'(o_err_cnt), 32'hFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
